tx_crc_append: RTL and testbench



---
 rtl/tx_crc_append.sv | 126 ++++++++++++
 tb/tb_tx_crc_append.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_crc_append.sv
// Bit-level Tx stage: passes payload bits through and optionally appends the captured 16-bit CRC_A, LSB first.
// Latency: payload 0 cycles (combinational), CRC_LATENCY-cycle gap after the last payload bit, then 16 registered CRC bits.
// Backpressure: out_req drives in_req while passing payload; CRC bits hold on out_req low; upstream stalled (in_req=0) during gap and CRC.
module tx_crc_append #(
    parameter int CRC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        append_crc,
    input  logic [15:0] crc,
    input  logic        in_data,
    input  logic        in_data_valid,
    input  logic        in_last_bit,
    output logic        in_req,
    output logic        out_data,
    output logic        out_data_valid,
    output logic        out_last_bit,
    input  logic        out_req
);

    localparam int WW = (CRC_LATENCY > 1) ? $clog2(CRC_LATENCY) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(CRC_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, PASS, WAIT_CRC, SEND_CRC} state_t;

    state_t        state, state_nxt;
    logic          appended_flag, appended_nxt;
    logic [15:0]   shreg, shreg_nxt;
    logic [3:0]    bit_idx, bit_idx_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            appended_flag <= 1'b0;
            shreg         <= '0;
            bit_idx       <= '0;
            wait_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            appended_flag <= appended_nxt;
            shreg         <= shreg_nxt;
            bit_idx       <= bit_idx_nxt;
            wait_cnt      <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        appended_nxt   = appended_flag;
        shreg_nxt      = shreg;
        bit_idx_nxt    = bit_idx;
        wait_cnt_nxt   = wait_cnt;
        in_req         = 1'b0;
        out_data       = 1'b0;
        out_data_valid = 1'b0;
        out_last_bit   = 1'b0;

        case (state)
            IDLE: begin
                out_data       = in_data;
                out_data_valid = in_data_valid;
                out_last_bit   = in_last_bit && !append_crc;
                in_req         = out_req;
                if (in_data_valid) begin
                    // Frame starts on the first valid bit, even if it is stalled downstream
                    appended_nxt = append_crc;
                    state_nxt    = PASS;
                    if (out_req && in_last_bit) begin
                        if (append_crc) begin
                            state_nxt    = WAIT_CRC;
                            wait_cnt_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            PASS: begin
                out_data       = in_data;
                out_data_valid = in_data_valid;
                out_last_bit   = in_last_bit && !appended_flag;
                in_req         = out_req;
                if (in_data_valid && out_req && in_last_bit) begin
                    if (appended_flag) begin
                        state_nxt    = WAIT_CRC;
                        wait_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_CRC: begin
                if (wait_cnt == WAIT_LAST) begin
                    shreg_nxt   = crc;
                    bit_idx_nxt = '0;
                    state_nxt   = SEND_CRC;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            SEND_CRC: begin
                out_data       = shreg[0];
                out_data_valid = 1'b1;
                out_last_bit   = (bit_idx == 4'd15);
                if (out_req) begin
                    shreg_nxt   = {1'b0, shreg[15:1]};
                    bit_idx_nxt = bit_idx + 4'd1;
                    if (bit_idx == 4'd15) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are quiet for the whole reset, not just after it
        if (rst) begin
            in_req         = 1'b0;
            out_data       = 1'b0;
            out_data_valid = 1'b0;
            out_last_bit   = 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_crc_append.sv
// Directed bench for tx_crc_append with a bit-serial CRC_A source model standing in for crc_control.
module tb_tx_crc_append;

    logic        clk = 1'b0;
    logic        rst;
    logic        append_crc;
    logic [15:0] crc;
    logic        in_data;
    logic        in_data_valid;
    logic        in_last_bit;
    logic        in_req;
    logic        out_data;
    logic        out_data_valid;
    logic        out_last_bit;
    logic        out_req;
    logic        crc_clr;

    always #5 clk = ~clk;

    tx_crc_append #(.CRC_LATENCY(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .append_crc     (append_crc),
        .crc            (crc),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_last_bit    (in_last_bit),
        .in_req         (in_req),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .out_last_bit   (out_last_bit),
        .out_req        (out_req)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ISO14443-A CRC, reflected poly 0x8408, one bit at a time
    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        logic [15:0] r;
        fb = c[0] ^ b;
        r  = c >> 1;
        if (fb) r = r ^ 16'h8408;
        return r;
    endfunction

    // crc_control stand-in: updates one cycle after each accepted bit
    always @(posedge clk) begin
        if (crc_clr) crc <= 16'h6363;
        else if (in_data_valid && in_req) crc <= crc_bit(crc, in_data);
    end

    logic [7:0] pay[$];
    logic       obits[$];
    logic       olast[$];
    int gap_cycles, inreq_bad, hold_bad, last_mis;

    function automatic logic [15:0] crc_golden();
        logic [15:0] c;
        c = 16'h6363;
        foreach (pay[i])
            for (int b = 0; b < 8; b++) c = crc_bit(c, pay[i][b]);
        return c;
    endfunction

    task automatic run_frame(input bit app, input bit toggle, input int bp_pct, input int rst_idx);
        int  nb;
        int  idx;
        bit  started;
        bit  done;
        logic prev_hold;
        logic prev_dat;
        nb = pay.size() * 8;
        idx = 0; started = 0; done = 0; prev_hold = 0; prev_dat = 0;
        obits.delete(); olast.delete();
        gap_cycles = 0; inreq_bad = 0; hold_bad = 0; last_mis = 0;
        @(negedge clk);
        crc_clr = 1; in_data_valid = 0; in_last_bit = 0; out_req = 1;
        @(negedge clk);
        crc_clr = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            out_req = ($urandom_range(99) >= bp_pct);
            if (idx < nb) begin
                in_data_valid = 1;
                in_data       = pay[idx/8][idx%8];
                in_last_bit   = (idx == nb - 1);
            end else begin
                in_data_valid = 0;
                in_data       = 0;
                in_last_bit   = 0;
            end
            append_crc = (toggle && idx > 0) ? !app : app;
            #1;
            if (prev_hold && out_data !== prev_dat) hold_bad++;
            if (idx >= nb && in_req !== 1'b0) inreq_bad++;
            if (started && !out_data_valid) gap_cycles++;
            if (out_data_valid) started = 1;
            if (rst_idx >= 0 && out_data_valid && obits.size() == nb + rst_idx) begin
                rst  = 1;
                done = 1;
            end else if (out_data_valid && out_req) begin
                obits.push_back(out_data);
                olast.push_back(out_last_bit);
                if (!app && out_last_bit !== (in_data_valid && in_last_bit)) last_mis++;
                if (out_last_bit) done = 1;
            end
            prev_hold = out_data_valid && !out_req;
            prev_dat  = out_data;
            if (in_data_valid && in_req) idx++;
            @(negedge clk);
        end
        if (!done) chk("timeout", 1, 0);
        in_data_valid = 0;
        in_last_bit   = 0;
        in_data       = 0;
    endtask

    task automatic verify(input string tag, input bit app, input logic [15:0] exp_crc);
        int nb;
        int mism;
        int nlast;
        logic [15:0] got_crc;
        nb = pay.size() * 8;
        mism = 0; nlast = 0; got_crc = '0;
        chk({tag, "_nbits"}, obits.size(), nb + (app ? 16 : 0));
        for (int i = 0; i < nb && i < obits.size(); i++)
            if (obits[i] !== pay[i/8][i%8]) mism++;
        chk({tag, "_payload"}, mism, 0);
        if (app) begin
            for (int k = 0; k < 16 && nb + k < obits.size(); k++) got_crc[k] = obits[nb+k];
            chk({tag, "_crc"}, got_crc, exp_crc);
        end
        foreach (olast[i]) if (olast[i]) nlast++;
        chk({tag, "_last_cnt"}, nlast, 1);
        if (olast.size() > 0) chk({tag, "_last_pos"}, olast[olast.size()-1], 1);
        chk({tag, "_hold"}, hold_bad, 0);
        chk({tag, "_inreq_crc"}, inreq_bad, 0);
        // back in IDLE: pass-through with nothing pending
        out_req = 1;
        #1;
        chk({tag, "_idle_req"}, in_req, 1);
        chk({tag, "_idle_vld"}, out_data_valid, 0);
    endtask

    initial begin
        rst = 1; append_crc = 0; in_data = 0; in_data_valid = 0; in_last_bit = 0;
        out_req = 0; crc_clr = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_req", in_req, 0);
        chk("rst_out_vld", out_data_valid, 0);
        chk("rst_out_last", out_last_bit, 0);
        chk("rst_out_data", out_data, 0);
        rst = 0;
        out_req = 1; append_crc = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_mirror_req", in_req, 1);
        chk("idle_no_vld", out_data_valid, 0);

        // 00 00 with CRC: A0 1E, one-cycle gap
        pay = '{8'h00, 8'h00};
        run_frame(1, 0, 0, -1);
        chk("f0000_gap", gap_cycles, 1);
        verify("f0000", 1, 16'h1EA0);

        // 12 34 with CRC: 26 CF
        pay = '{8'h12, 8'h34};
        run_frame(1, 0, 0, -1);
        verify("f1234", 1, 16'hCF26);

        // no CRC, 3 bytes: no gap, last bit aligned with upstream
        pay = '{8'hA1, 8'hB2, 8'hC3};
        run_frame(0, 0, 0, -1);
        chk("noapp_gap", gap_cycles, 0);
        chk("noapp_last_align", last_mis, 0);
        verify("noapp", 0, 16'h0);

        // 50% downstream backpressure over payload and CRC
        for (int f = 0; f < 4; f++) begin
            pay.delete();
            for (int b = 0; b < 2 + f; b++) pay.push_back(8'($urandom_range(255)));
            run_frame(1, 0, 50, -1);
            verify("bp", 1, crc_golden());
        end

        // append_crc dropped after first bit: CRC still appended; next frame starting at 0 has none
        pay = '{8'h5A, 8'hC3};
        run_frame(1, 1, 0, -1);
        verify("toggle_on", 1, crc_golden());
        pay = '{8'h77};
        run_frame(0, 0, 0, -1);
        verify("toggle_off", 0, 16'h0);

        // reset while CRC bit 7 is on the bus
        pay = '{8'hF0, 8'h0F};
        run_frame(1, 0, 0, 7);
        #1;
        chk("midrst_in_req", in_req, 0);
        chk("midrst_vld", out_data_valid, 0);
        chk("midrst_last", out_last_bit, 0);
        chk("midrst_data", out_data, 0);
        rst = 0;
        #1;
        chk("midrst_idle_req", in_req, out_req);
        chk("midrst_idle_vld", out_data_valid, 0);
        pay = '{8'hA5};
        run_frame(0, 0, 0, -1);
        verify("after_rst", 0, 16'h0);

        // random payloads against the golden CRC
        for (int f = 0; f < 200; f++) begin
            pay.delete();
            for (int b = 0; b < int'($urandom_range(10, 1)); b++) pay.push_back(8'($urandom_range(255)));
            run_frame(1, 0, 0, -1);
            verify("rand", 1, crc_golden());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
